// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for the multi-cycle multiply and divide units.
// It latches one mul/div op, holds EX stalled, and owns the single HI/LO write port.
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [3:0]  op_sel,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_annul,
  output logic        div_signed,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        stallreq_for_ex,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        busy
);

  // state    | meaning
  // S_IDLE   | no op in flight; may accept one from EX
  // S_MUL_RUN| waiting MUL_LAT cycles for the mul unit
  // S_DIV_RUN| div unit started; waiting for div_ready
  // S_DONE   | result captured; one-cycle HI/LO write
  typedef enum logic [1:0] {S_IDLE, S_MUL_RUN, S_DIV_RUN, S_DONE} state_t;

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]   r_src1, w_src1_nxt;
  logic [31:0]   r_src2, w_src2_nxt;
  logic          r_signed, w_signed_nxt;
  logic [31:0]   r_hi, w_hi_nxt;
  logic [31:0]   r_lo, w_lo_nxt;

  logic w_any_div;
  logic w_sel_signed;
  logic w_accept;
  logic w_mul_run;
  logic w_div_run;
  logic w_done;

  // Priority div > divu > mult > multu: the signed variants win only over their own unsigned twin.
  assign w_any_div    = op_sel[3] | op_sel[2];
  assign w_sel_signed = op_sel[3] | (~op_sel[2] & op_sel[1]);
  assign w_accept     = (r_state == S_IDLE) & op_valid & ~flush & (|op_sel);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_src1_nxt   = r_src1;
    w_src2_nxt   = r_src2;
    w_signed_nxt = r_signed;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_src1_nxt   = src1;
          w_src2_nxt   = src2;
          w_signed_nxt = w_sel_signed;
          if (w_any_div) begin
            if (src2 == 32'd0) begin
              // Divide by zero bypasses the div unit entirely.
              w_hi_nxt    = src1;
              w_lo_nxt    = 32'hFFFF_FFFF;
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_DIV_RUN;
            end
          end else begin
            w_cnt_nxt   = CW'(MUL_LAT - 1);
            w_state_nxt = S_MUL_RUN;
          end
        end
      end
      S_MUL_RUN: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_hi_nxt    = mul_result[63:32];
          w_lo_nxt    = mul_result[31:0];
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_DIV_RUN: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (div_ready) begin
          w_hi_nxt    = div_result[63:32];
          w_lo_nxt    = div_result[31:0];
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_src1   <= '0;
      r_src2   <= '0;
      r_signed <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_src1   <= w_src1_nxt;
      r_src2   <= w_src2_nxt;
      r_signed <= w_signed_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
    end
  end

  assign w_mul_run = (r_state == S_MUL_RUN);
  assign w_div_run = (r_state == S_DIV_RUN);
  assign w_done    = (r_state == S_DONE);

  assign mul_signed  = w_mul_run & r_signed;
  assign mul_ina     = w_mul_run ? r_src1 : 32'd0;
  assign mul_inb     = w_mul_run ? r_src2 : 32'd0;

  assign div_start   = w_div_run;
  assign div_annul   = w_div_run & flush;
  assign div_signed  = w_div_run & r_signed;
  assign div_opdata1 = w_div_run ? r_src1 : 32'd0;
  assign div_opdata2 = w_div_run ? r_src2 : 32'd0;

  // A flush releases EX immediately, even mid-operation.
  assign stallreq_for_ex = w_accept | ((w_mul_run | w_div_run) & ~flush);

  assign hilo_we  = w_done;
  assign hi_wdata = w_done ? r_hi : 32'd0;
  assign lo_wdata = w_done ? r_lo : 32'd0;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: transaction-level model plus behavioural mul/div units,
// directed scenarios with literal expectations, then randomized traffic.
module tb_muldiv_ctrl;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        resetn, flush, op_valid;
  logic [3:0]  op_sel;
  logic [31:0] src1, src2;
  logic        mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result;
  logic        div_start, div_annul, div_signed;
  logic [31:0] div_opdata1, div_opdata2;
  logic        div_ready;
  logic [63:0] div_result;
  logic        stallreq_for_ex, hilo_we, busy;
  logic [31:0] hi_wdata, lo_wdata;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .op_valid(op_valid), .op_sel(op_sel),
    .src1(src1), .src2(src2), .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
    .mul_result(mul_result), .div_start(div_start), .div_annul(div_annul),
    .div_signed(div_signed), .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
    .div_ready(div_ready), .div_result(div_result), .stallreq_for_ex(stallreq_for_ex),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Transaction model: an op is either in flight (pending) or its write is due.
  bit          m_pend, m_div, m_wr, m_sgn;
  int          m_left, m_dwait;
  logic [31:0] m_a, m_b, m_hi, m_lo;
  int          div_lat_next = 3;

  int          obs_stall, obs_start, obs_start_sgn, obs_annul;
  logic [31:0] q_hi[$];
  logic [31:0] q_lo[$];

  function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b, input bit s);
    logic [63:0] x, y;
    x = s ? {{32{a[31]}}, a} : {32'd0, a};
    y = s ? {{32{b[31]}}, b} : {32'd0, b};
    return x * y;
  endfunction

  // Returns {remainder, quotient}; a zero divisor yields the controller's bypass value.
  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input bit s);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = a; sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sr, sq};
    end
    return {a % b, a / b};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_pend = 0; m_div = 0; m_wr = 0; m_sgn = 0;
    m_left = 0; m_dwait = 0;
  endtask

  task automatic clear_obs();
    obs_stall = 0; obs_start = 0; obs_start_sgn = 0; obs_annul = 0;
    q_hi.delete(); q_lo.delete();
  endtask

  // One clock cycle: drive inputs, emulate units, compare, advance model.
  task automatic step(input bit rn, input bit fl, input bit ov, input logic [3:0] sel,
                      input logic [31:0] a, input logic [31:0] b);
    bit acc, run_mul, run_div, exp_stall;
    resetn = rn; flush = fl; op_valid = ov; op_sel = sel; src1 = a; src2 = b;
    run_mul = m_pend && !m_div;
    run_div = m_pend && m_div;
    #1;
    if (run_mul && m_left == 0) mul_result = mul_ref(mul_ina, mul_inb, mul_signed);
    else mul_result = {$urandom, $urandom};
    div_ready = run_div && (m_dwait == 0);
    if (div_ready) div_result = div_ref(div_opdata1, div_opdata2, div_signed);
    else div_result = {$urandom, $urandom};
    #1;
    acc = !m_pend && !m_wr && ov && !fl && (sel != 4'd0);
    exp_stall = acc || (m_pend && !fl);
    chk("stallreq", stallreq_for_ex, exp_stall);
    chk("busy", busy, m_pend || m_wr);
    chk("hilo_we", hilo_we, m_wr);
    chk("hi_wdata", hi_wdata, m_wr ? m_hi : 32'd0);
    chk("lo_wdata", lo_wdata, m_wr ? m_lo : 32'd0);
    chk("mul_signed", mul_signed, run_mul && m_sgn);
    chk("mul_ina", mul_ina, run_mul ? m_a : 32'd0);
    chk("mul_inb", mul_inb, run_mul ? m_b : 32'd0);
    chk("div_start", div_start, run_div);
    chk("div_annul", div_annul, run_div && fl);
    chk("div_signed", div_signed, run_div && m_sgn);
    chk("div_opdata1", div_opdata1, run_div ? m_a : 32'd0);
    chk("div_opdata2", div_opdata2, run_div ? m_b : 32'd0);
    if (stallreq_for_ex) obs_stall++;
    if (div_start) obs_start++;
    if (div_start && div_signed) obs_start_sgn++;
    if (div_annul) obs_annul++;
    if (hilo_we) begin q_hi.push_back(hi_wdata); q_lo.push_back(lo_wdata); end

    if (!rn) begin
      model_clear();
    end else if (m_wr) begin
      m_wr = 0;
    end else if (m_pend) begin
      if (fl) m_pend = 0;
      else if (!m_div) begin
        if (m_left == 0) begin m_pend = 0; m_wr = 1; end
        else m_left--;
      end else begin
        if (m_dwait == 0) begin m_pend = 0; m_wr = 1; end
        else m_dwait--;
      end
    end else if (acc) begin
      m_a = a; m_b = b;
      m_div = sel[3] | sel[2];
      m_sgn = sel[3] ? 1'b1 : sel[2] ? 1'b0 : sel[1];
      if (m_div) begin
        {m_hi, m_lo} = div_ref(a, b, m_sgn);
        if (b == 32'd0) m_wr = 1;
        else begin m_pend = 1; m_dwait = div_lat_next - 1; end
      end else begin
        {m_hi, m_lo} = mul_ref(a, b, m_sgn);
        m_pend = 1; m_left = MUL_LAT - 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 4'd0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] qv(input bit hi, input int idx);
    if (hi) return (q_hi.size() > idx) ? q_hi[idx] : 32'hDEAD_BEEF;
    return (q_lo.size() > idx) ? q_lo[idx] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  rs;
    resetn = 0; flush = 0; op_valid = 0; op_sel = 0; src1 = 0; src2 = 0;
    mul_result = 0; div_ready = 0; div_result = 0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    clear_obs();

    idle(2);
    chk("reset_busy", busy, 0);
    chk("reset_hilo_we", hilo_we, 0);

    // multu 3*5
    clear_obs();
    step(1, 0, 1, 4'b0001, 32'd3, 32'd5);
    idle(4);
    chk("t1_stall_cycles", obs_stall, 3);
    chk("t1_pulses", q_hi.size(), 1);
    chk("t1_hi", qv(1, 0), 32'd0);
    chk("t1_lo", qv(0, 0), 32'd15);

    // div -7/2, ready on the 4th running cycle
    clear_obs();
    div_lat_next = 4;
    step(1, 0, 1, 4'b1000, 32'hFFFF_FFF9, 32'd2);
    idle(6);
    chk("t2_start_cycles", obs_start, 4);
    chk("t2_signed_cycles", obs_start_sgn, 4);
    chk("t2_hi", qv(1, 0), 32'hFFFF_FFFF);
    chk("t2_lo", qv(0, 0), 32'hFFFF_FFFD);

    // divu by zero
    clear_obs();
    step(1, 0, 1, 4'b0100, 32'h1234, 32'd0);
    idle(3);
    chk("t3_start_cycles", obs_start, 0);
    chk("t3_pulses", q_hi.size(), 1);
    chk("t3_hi", qv(1, 0), 32'h1234);
    chk("t3_lo", qv(0, 0), 32'hFFFF_FFFF);

    // flush coincident with div_ready
    clear_obs();
    div_lat_next = 3;
    step(1, 0, 1, 4'b1000, 32'd50, 32'd5);
    idle(2);
    step(1, 1, 0, 4'd0, 32'd0, 32'd0);
    chk("t4_busy_after", busy, 0);
    idle(3);
    chk("t4_annul_cycles", obs_annul, 1);
    chk("t4_pulses", q_hi.size(), 0);

    // back-to-back mult then div, op_valid held
    clear_obs();
    div_lat_next = 2;
    for (int i = 0; i < MUL_LAT + 2; i++) step(1, 0, 1, 4'b0010, 32'd6, 32'd7);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 4'b1000, 32'd100, 32'd7);
    idle(2);
    chk("t5_pulses", q_hi.size(), 2);
    chk("t5_p0_hi", qv(1, 0), 32'd0);
    chk("t5_p0_lo", qv(0, 0), 32'd42);
    chk("t5_p1_hi", qv(1, 1), 32'd2);
    chk("t5_p1_lo", qv(0, 1), 32'd14);

    // reset pulse during MUL_RUN
    clear_obs();
    step(1, 0, 1, 4'b0001, 32'd9, 32'd9);
    step(0, 0, 0, 4'd0, 32'd0, 32'd0);
    chk("t6_busy", busy, 0);
    chk("t6_stall", stallreq_for_ex, 0);
    chk("t6_mul_ina", mul_ina, 0);
    idle(3);
    chk("t6_pulses", q_hi.size(), 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1, 2: rb = $urandom_range(1, 20);
        3: rb = -$urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      rs = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (4'd1 << $urandom_range(0, 3));
      div_lat_next = $urandom_range(1, 6);
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 1), rs, ra, rb);
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
